multi_reg_transfer: RTL and testbench
=====================================

Name: multi_reg_transfer

Overview:
- Sequencer for the Thumb multi-register instructions: LDM, STM, PUSH and POP.
- Sits between decode/execute and the 16x32 register file.
  - Walks a register list lowest index first.
  - For stores, drives the register-file read port.
  - For loads, drives the register-file write port.
  - Issues one word-wide memory access per register, then optionally writes back the base register.
- Core stalls while busy is high.

Parameters:
DATA_N, 32, data/address width
SIZE, 16, number of architectural registers; register index width is $clog2(SIZE)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin transfer; sampled only in IDLE
is_load  input  1  1 = LDM/POP, 0 = STM/PUSH
decrement  input  1  1 = full-descending (PUSH): start address = base - 4*count
writeback_en  input  1  update base register after transfer
reg_list  input  SIZE  bit i set = transfer register i
base_reg  input  $clog2(SIZE)  base register index
base_addr  input  DATA_N  current value of base register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
mem_req  output  1  memory access request
mem_we  output  1  1 = write
mem_addr  output  DATA_N  word address, bits[1:0] always 0
mem_wdata  output  DATA_N  store data
mem_ready  input  1  access accepted/completed this cycle
mem_rdata  input  DATA_N  load data, valid when mem_req & mem_ready & !mem_we
rf_r_addr  output  $clog2(SIZE)  register-file read address (store data source)
rf_r_data  input  DATA_N  register-file read data (combinational)
rf_w_addr  output  $clog2(SIZE)  register-file write address
rf_w_data  output  DATA_N  register-file write data
rf_wr_en  output  1  register-file write enable

Behaviour:
- States: IDLE, XFER, WB, DONE.
- Reset (rst high at posedge) forces IDLE. All outputs are 0 in IDLE and after reset. Reset mid-operation aborts with no done pulse and no further memory or register writes.
- IDLE, start=1: latch the following.
  - reg_list into a remaining-list register.
  - count = popcount(reg_list), width $clog2(SIZE)+1.
  - base_addr with bits[1:0] cleared.
  - Start address = decrement ? base - 4*count : base.
  - is_load, writeback_en, base_reg.
  - Next state is XFER, or DONE if reg_list == 0 (no memory access, no writeback).
- XFER:
  - cur = index of lowest set bit of the remaining list.
  - mem_req=1; mem_we=!is_load; mem_addr = current address.
  - rf_r_addr = cur; mem_wdata = rf_r_data.
  - mem_req, mem_addr and mem_wdata stay stable while mem_ready=0.
- XFER, mem_ready=1:
  - Load: rf_wr_en=1, rf_w_addr=cur, rf_w_data=mem_rdata in the same cycle.
  - Clear bit cur; address += 4.
  - If this was the last bit, go to WB if writeback_en, else DONE.
- rf_wr_en is 0 in XFER when mem_ready=0 or for stores.
- WB:
  - rf_wr_en=1, rf_w_addr=base_reg.
  - rf_w_data = decrement ? base - 4*count : base + 4*count (mod 2^DATA_N).
  - Exception: if is_load and base_reg is in the latched list, suppress the write (rf_wr_en=0); the loaded value wins.
  - Next state is DONE.
- DONE: done=1 for one cycle, then IDLE. start is ignored in every state except IDLE.
- Timing:
  - Addresses always ascend; for decrement, the lowest register goes to the lowest address.
  - With mem_ready tied high: first mem_req one cycle after start; N transfers take N cycles, then WB 1 cycle (if enabled), then DONE 1 cycle.
- Arithmetic wraps modulo 2^DATA_N; no alignment faults are raised.

Test Plan:
1. Load, list 0x0013, base 0x1000, increment, writeback, base_reg 5, ready=1 -> reads at 0x1000/0x1004/0x1008 write r0, r1, r4 on cycles 1-3; r5=0x100C on cycle 4; done on cycle 5.
2. PUSH: store, decrement, list 0x40F0, base 0x2000, base_reg 13 -> stores r4, r5, r6, r7, r14 at 0x1FEC, 0x1FF0, 0x1FF4, 0x1FF8, 0x1FFC with wdata = rf contents; r13=0x1FEC.
3. Wait states: mem_ready low for 2 cycles on the second access -> mem_addr/mem_wdata held constant and no rf write until ready; done 2 cycles later than in case 1.
4. Load with base in list: list 0x0006, base_reg 1, writeback on -> r1 and r2 loaded from memory; WB cycle has rf_wr_en=0; done asserted.
5. Empty list with start -> no mem_req, no rf_wr_en, done pulse one cycle after start, busy high for exactly one cycle.
6. rst asserted during the second XFER of a 4-register load -> next cycle IDLE with all outputs 0 and no done. A start pulse while busy (in a separate run) is ignored, and the transfer in progress completes unchanged.

Source files
------------

// File: rtl/multi_reg_transfer.sv
// Multi-register transfer sequencer for Thumb LDM/STM/PUSH/POP.
// Walks the register list lowest index first. It issues one word access per
// register: stores read the register file, loads write it. It then optionally
// writes the updated base back. The core stalls while busy is high.
module multi_reg_transfer #(
  parameter int DATA_N = 32,
  parameter int SIZE   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_load,
  input  logic                     decrement,
  input  logic                     writeback_en,
  input  logic [SIZE-1:0]          reg_list,
  input  logic [$clog2(SIZE)-1:0]  base_reg,
  input  logic [DATA_N-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_N-1:0]        mem_addr,
  output logic [DATA_N-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_N-1:0]        mem_rdata,
  output logic [$clog2(SIZE)-1:0]  rf_r_addr,
  input  logic [DATA_N-1:0]        rf_r_data,
  output logic [$clog2(SIZE)-1:0]  rf_w_addr,
  output logic [DATA_N-1:0]        rf_w_data,
  output logic                     rf_wr_en
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SIZE-1:0]     list_q, list_d;          // registers still to transfer
  logic [CW-1:0]       count_q, count_d;        // popcount of the original list
  logic [DATA_N-1:0]   base_q, base_d;          // word-aligned base value
  logic [DATA_N-1:0]   addr_q, addr_d;          // address of the current access
  logic                is_load_q, is_load_d;
  logic                decrement_q, decrement_d;
  logic                writeback_q, writeback_d;
  logic                base_in_list_q, base_in_list_d;
  logic [IW-1:0]       base_reg_q, base_reg_d;

  logic [CW-1:0]       start_count;
  logic [IW-1:0]       cur_idx;
  logic                last_bit;
  logic [DATA_N-1:0]   aligned_base;
  logic [DATA_N-1:0]   start_offset;
  logic [DATA_N-1:0]   xfer_offset;
  logic [DATA_N-1:0]   wb_value;

  // Popcount of the incoming list, used to size the block and its address span.
  always_comb begin
    start_count = '0;
    for (int i = 0; i < SIZE; i++) begin
      start_count = start_count + CW'(reg_list[i]);
    end
  end

  // Lowest set bit of the remaining list. The scan runs downwards so that the
  // last match, which is the lowest index, is the one that sticks.
  always_comb begin
    cur_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (list_q[i]) cur_idx = IW'(i);
    end
  end

  // Address arithmetic shared by the start latch and the base write-back.
  always_comb begin
    aligned_base = base_addr & ~DATA_N'(3);
    start_offset = DATA_N'(start_count) << 2;
    xfer_offset  = DATA_N'(count_q) << 2;
    wb_value     = decrement_q ? (base_q - xfer_offset) : (base_q + xfer_offset);
    last_bit     = (list_q & (list_q - SIZE'(1))) == '0;
  end

  // Next-state and output decode for the transfer sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path leaves it unassigned and no latch is inferred.
    state_d        = state_q;
    list_d         = list_q;
    count_d        = count_q;
    base_d         = base_q;
    addr_d         = addr_q;
    is_load_d      = is_load_q;
    decrement_d    = decrement_q;
    writeback_d    = writeback_q;
    base_in_list_d = base_in_list_q;
    base_reg_d     = base_reg_q;

    busy      = (state_q != IDLE);
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_r_addr = '0;
    rf_w_addr = '0;
    rf_w_data = '0;
    rf_wr_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          list_d         = reg_list;
          count_d        = start_count;
          base_d         = aligned_base;
          addr_d         = decrement ? (aligned_base - start_offset) : aligned_base;
          is_load_d      = is_load;
          decrement_d    = decrement;
          writeback_d    = writeback_en;
          base_in_list_d = reg_list[base_reg];
          base_reg_d     = base_reg;
          state_d        = (reg_list == '0) ? DONE : XFER;
        end
      end

      XFER: begin
        mem_req   = 1'b1;
        mem_we    = !is_load_q;
        mem_addr  = addr_q;
        rf_r_addr = cur_idx;
        mem_wdata = is_load_q ? '0 : rf_r_data;
        if (mem_ready) begin
          rf_wr_en  = is_load_q;
          rf_w_addr = is_load_q ? cur_idx : '0;
          rf_w_data = is_load_q ? mem_rdata : '0;
          list_d    = list_q & (list_q - SIZE'(1));
          addr_d    = addr_q + DATA_N'(4);
          if (last_bit) state_d = writeback_q ? WB : DONE;
        end
      end

      WB: begin
        // A load that lists its own base keeps the loaded value.
        rf_wr_en  = !(is_load_q && base_in_list_q);
        rf_w_addr = base_reg_q;
        rf_w_data = wb_value;
        state_d   = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (rst) begin
      state_q        <= IDLE;
      list_q         <= '0;
      count_q        <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      is_load_q      <= 1'b0;
      decrement_q    <= 1'b0;
      writeback_q    <= 1'b0;
      base_in_list_q <= 1'b0;
      base_reg_q     <= '0;
    end else begin
      state_q        <= state_d;
      list_q         <= list_d;
      count_q        <= count_d;
      base_q         <= base_d;
      addr_q         <= addr_d;
      is_load_q      <= is_load_d;
      decrement_q    <= decrement_d;
      writeback_q    <= writeback_d;
      base_in_list_q <= base_in_list_d;
      base_reg_q     <= base_reg_d;
    end
  end

endmodule

// File: tb/tb_multi_reg_transfer.sv
// Self-checking bench for multi_reg_transfer. It contains a register-file
// model, a memory whose load data comes from a hash of the address, and a
// transaction-level reference model of the expected transfer sequence.
module tb_multi_reg_transfer;

  localparam int DATA_N = 32;
  localparam int SIZE   = 16;
  localparam int IW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              is_load = 1'b0;
  logic              decrement = 1'b0;
  logic              writeback_en = 1'b0;
  logic [SIZE-1:0]   reg_list = '0;
  logic [IW-1:0]     base_reg = '0;
  logic [DATA_N-1:0] base_addr = '0;
  logic              mem_ready = 1'b0;
  logic              busy, done, mem_req, mem_we, rf_wr_en;
  logic [DATA_N-1:0] mem_addr, mem_wdata, mem_rdata, rf_r_data, rf_w_data;
  logic [IW-1:0]     rf_r_addr, rf_w_addr;

  logic              rf_init = 1'b1;
  logic [31:0]       salt = 32'h1234_5678;
  logic [31:0]       rf_mem   [SIZE];
  logic [31:0]       rf_model [SIZE];
  logic [108:0]      all_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_reg_transfer #(.DATA_N(DATA_N), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_load      (is_load),
    .decrement    (decrement),
    .writeback_en (writeback_en),
    .reg_list     (reg_list),
    .base_reg     (base_reg),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .rf_r_addr    (rf_r_addr),
    .rf_r_data    (rf_r_data),
    .rf_w_addr    (rf_w_addr),
    .rf_w_data    (rf_w_data),
    .rf_wr_en     (rf_wr_en)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic [31:0] s);
    return (addr * 32'h9E37_79B1) ^ s;
  endfunction

  function automatic logic [31:0] rf_seed(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0111;
  endfunction

  assign mem_rdata = mem_word(mem_addr, salt);
  assign rf_r_data = rf_mem[rf_r_addr];
  assign all_out   = {busy, done, mem_req, mem_we, mem_addr, mem_wdata,
                      rf_r_addr, rf_w_addr, rf_w_data, rf_wr_en};

  // Register file written by the DUT write port.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < SIZE; i++) rf_mem[i] <= rf_seed(i);
    end else if (rf_wr_en) begin
      rf_mem[rf_w_addr] <= rf_w_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sampling point: drop start, drive ready, settle.
  task automatic step(input bit rdy);
    @(negedge clk);
    start     = 1'b0;
    mem_ready = rdy;
    #1;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < SIZE; i++) check(tag, rf_mem[i], rf_model[i]);
  endtask

  // One complete instruction, checked cycle by cycle against the model.
  // wait_mode: 0 = always ready, 1 = random waits, 2 = two waits on access 1.
  task automatic run_op(input logic [15:0] list, input logic [31:0] base, input logic [3:0] br,
                        input bit ld, input bit dec, input bit wb,
                        input int wait_mode, input bit glitch);
    int          regs[$];
    int          n, k, cyc, waited;
    bit          rdy;
    logic [31:0] bc, st, wbv, exp_addr;

    regs = {};
    for (int i = 0; i < SIZE; i++) if (list[i]) regs.push_back(i);
    n   = regs.size();
    bc  = base & 32'hFFFF_FFFC;
    st  = dec ? bc - 32'(4 * n) : bc;
    wbv = dec ? bc - 32'(4 * n) : bc + 32'(4 * n);
    salt = $urandom();

    @(negedge clk);
    start = 1'b1; reg_list = list; base_addr = base; base_reg = br;
    is_load = ld; decrement = dec; writeback_en = wb; mem_ready = 1'b1;
    #1;
    check("idle_before_start", {19'd0, all_out}, 128'd0);

    k = 0; cyc = 0; waited = 0;
    while (k < n) begin
      case (wait_mode)
        0:       rdy = 1'b1;
        1:       rdy = (waited >= 3) || ($urandom_range(0, 2) != 0);
        default: rdy = !(k == 1 && waited < 2);
      endcase
      step(rdy);
      cyc++;
      if (glitch && cyc == 2) begin
        start = 1'b1; reg_list = 16'($urandom()); base_addr = $urandom();
        base_reg = 4'($urandom()); is_load = !ld; decrement = !dec; writeback_en = !wb;
      end
      exp_addr = st + 32'(k) * 32'd4;
      check("xfer_busy", busy, 1);
      check("xfer_done", done, 0);
      check("xfer_req", mem_req, 1);
      check("xfer_we", mem_we, !ld);
      check("xfer_addr", mem_addr, exp_addr);
      if (!ld) check("xfer_wdata", mem_wdata, rf_model[regs[k]]);
      check("xfer_rf_wr_en", rf_wr_en, ld && rdy);
      if (ld && rdy) begin
        check("xfer_rf_w_addr", rf_w_addr, regs[k]);
        check("xfer_rf_w_data", rf_w_data, mem_word(exp_addr, salt));
        rf_model[regs[k]] = mem_word(exp_addr, salt);
      end
      if (rdy) begin
        k++;
        waited = 0;
      end else begin
        waited++;
      end
    end

    if (wb && n > 0) begin
      step(1'($urandom_range(0, 1)));
      check("wb_busy", busy, 1);
      check("wb_done", done, 0);
      check("wb_req", mem_req, 0);
      check("wb_rf_wr_en", rf_wr_en, !(ld && list[br]));
      if (!(ld && list[br])) begin
        check("wb_rf_w_addr", rf_w_addr, br);
        check("wb_rf_w_data", rf_w_data, wbv);
        rf_model[br] = wbv;
      end
    end

    step(1'($urandom_range(0, 1)));
    check("done_busy", busy, 1);
    check("done_pulse", done, 1);
    check("done_req", mem_req, 0);
    check("done_rf_wr_en", rf_wr_en, 0);

    step(1'($urandom_range(0, 1)));
    check("idle_after_done", {19'd0, all_out}, 128'd0);
    check_rf("rf_contents");
  endtask

  initial begin
    logic [15:0] rl;
    logic [31:0] rb;

    for (int i = 0; i < SIZE; i++) rf_model[i] = rf_seed(i);
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {19'd0, all_out}, 128'd0);
    rst = 1'b0;
    rf_init = 1'b0;
    @(negedge clk);
    #1;
    check("idle_no_start", {19'd0, all_out}, 128'd0);

    // LDM r0,r1,r4 with write-back of r5.
    run_op(16'h0013, 32'h0000_1000, 4'd5, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("ldm_base_r5", rf_mem[5], 32'h0000_100C);

    // PUSH {r4-r7, lr} through sp.
    run_op(16'h40F0, 32'h0000_2000, 4'd13, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    check("push_sp_r13", rf_mem[13], 32'h0000_1FEC);

    // Same load as the first, with two wait states on the second access.
    run_op(16'h0013, 32'h0000_1000, 4'd5, 1'b1, 1'b0, 1'b1, 2, 1'b0);

    // Load whose list includes the base register: write-back suppressed.
    run_op(16'h0006, 32'h0000_4000, 4'd1, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    // Empty list: straight to the completion pulse.
    run_op(16'h0000, 32'h0000_5000, 4'd2, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Start pulses while busy are ignored.
    run_op(16'h0F00, 32'h0000_6000, 4'd3, 1'b1, 1'b0, 1'b1, 1, 1'b1);

    // Reset during the second access of a four-register load.
    salt = $urandom();
    @(negedge clk);
    start = 1'b1; reg_list = 16'h00F0; base_addr = 32'h0000_3000; base_reg = 4'd0;
    is_load = 1'b1; decrement = 1'b0; writeback_en = 1'b1; mem_ready = 1'b1;
    #1;
    step(1'b1);
    check("abort_first_addr", mem_addr, 32'h0000_3000);
    check("abort_first_wr", rf_wr_en, 1);
    rf_model[4] = mem_word(32'h0000_3000, salt);
    step(1'b0);
    check("abort_second_req", mem_req, 1);
    check("abort_second_addr", mem_addr, 32'h0000_3004);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("abort_idle", {19'd0, all_out}, 128'd0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1);
      check("abort_stays_idle", {19'd0, all_out}, 128'd0);
    end
    check_rf("abort_rf_contents");

    // Randomized instructions, including full lists and address wrap.
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 4))
        0:       rl = 16'h0000;
        1:       rl = 16'hFFFF;
        2:       rl = 16'h0001 << $urandom_range(0, 15);
        default: rl = 16'($urandom());
      endcase
      case ($urandom_range(0, 2))
        0:       rb = 32'($urandom_range(0, 40));
        1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        default: rb = $urandom();
      endcase
      run_op(rl, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
